// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU program sequencer: word layout, op/select codes, FSM states.
package cpu_seq_pkg;

    localparam int unsigned WORD_W   = 17;
    localparam int unsigned LOAD_BIT = 16;
    localparam int unsigned CIN_BIT  = 15;
    localparam int unsigned SEL_HI   = 14;
    localparam int unsigned SEL_LO   = 12;
    localparam int unsigned OP_HI    = 11;
    localparam int unsigned OP_LO    = 8;
    localparam int unsigned DATA_HI  = 7;
    localparam int unsigned DATA_LO  = 0;

    localparam int unsigned OPC_W  = 7;
    localparam int unsigned DATA_W = 8;

    // ALU op nibble, shared with the CPU; 4'hB..4'hE pass through unchecked.
    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_CPY = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Register select, shared with the CPU.
    localparam logic [2:0] SEL_ACCU = 3'b000;
    localparam logic [2:0] SEL_REG0 = 3'b001;
    localparam logic [2:0] SEL_REG1 = 3'b010;
    localparam logic [2:0] SEL_REG2 = 3'b011;
    localparam logic [2:0] SEL_REG3 = 3'b100;
    localparam logic [2:0] SEL_REG4 = 3'b101;
    localparam logic [2:0] SEL_REG5 = 3'b110;
    localparam logic [2:0] SEL_REG6 = 3'b111;

    typedef struct packed {
        logic       load;
        logic       cin;
        logic [2:0] sel;
        logic [3:0] op;
        logic [7:0] data;
    } prog_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A HALT is a non-load word carrying the HALT op nibble.
    function automatic logic is_halt(input prog_word_t w);
        return (!w.load) && (w.op == OP_HALT);
    endfunction

endpackage

// File: rtl/cpu_sequencer_prog_ram.sv
// Program memory: one synchronous write port, one enabled synchronous read port.
module prog_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned W     = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;
    logic [W-1:0] rdata_d;

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its value unless a read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Program sequencer: fetches words from on-chip memory and issues one CPU op every two cycles.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [16:0]   prog_wdata,
    input  logic          start,
    input  logic          pause,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [6:0]    cpu_opcode,
    output logic [7:0]    cpu_data,
    output logic          cpu_cin,
    output logic          cpu_load,
    output logic          cpu_ce,
    input  logic          cpu_cout,
    output logic          carry_flag
);

    state_e              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                cin_q, cin_d;
    logic                load_q, load_d;
    logic                ce_q, ce_d;
    logic                carry_q, carry_d;
    logic                cap_q, cap_d;

    logic                ram_we;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [WORD_W-1:0]   ram_rdata;
    prog_word_t          rd_word;

    assign ram_we  = prog_we && (state_q == ST_IDLE);
    assign rd_word = prog_word_t'(ram_rdata);

    // The read for the next FETCH is launched on the edge entering FETCH, so the
    // word is already valid while FETCH decides; pause simply holds that word.
    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (WORD_W)
    ) u_prog_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Next-state, issue and carry-capture logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        data_d  = data_q;
        cin_d   = cin_q;
        load_d  = load_q;
        ce_d    = 1'b0;
        cap_d   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = pc_q;
        carry_d = cap_q ? cpu_cout : carry_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!pause) begin
                    if (is_halt(rd_word)) begin
                        state_d = ST_DONE;
                    end else begin
                        opc_d   = {rd_word.sel, rd_word.op};
                        data_d  = rd_word.data;
                        cin_d   = rd_word.cin;
                        load_d  = rd_word.load;
                        ce_d    = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                load_d = 1'b0;
                cap_d  = !load_q;
                if (pc_q == AW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    rd_en   = 1'b1;
                    rd_addr = pc_q + AW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_ISSUE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            opc_q   <= '0;
            data_q  <= '0;
            cin_q   <= 1'b0;
            load_q  <= 1'b0;
            ce_q    <= 1'b0;
            carry_q <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            opc_q   <= opc_d;
            data_q  <= data_d;
            cin_q   <= cin_d;
            load_q  <= load_d;
            ce_q    <= ce_d;
            carry_q <= carry_d;
            cap_q   <= cap_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pc         = pc_q;
    assign cpu_opcode = opc_q;
    assign cpu_data   = data_q;
    assign cpu_cin    = cin_q;
    assign cpu_load   = load_q;
    assign cpu_ce     = ce_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer.
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [16:0]   prog_wdata;
    logic          start;
    logic          pause;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [6:0]    cpu_opcode;
    logic [7:0]    cpu_data;
    logic          cpu_cin;
    logic          cpu_load;
    logic          cpu_ce;
    logic          cpu_cout;
    logic          carry_flag;

    int pass_n = 0;
    int total_n = 0;

    int         ce_n, done_n, done_at, pc_done;
    int         ce_at [128];
    logic       ld_at [128];
    logic [6:0] op_at [128];
    logic [7:0] dat_at[128];
    logic       carry_at[128];
    logic       busy_at [128];

    cpu_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .pause      (pause),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .cpu_opcode (cpu_opcode),
        .cpu_data   (cpu_data),
        .cpu_cin    (cpu_cin),
        .cpu_load   (cpu_load),
        .cpu_ce     (cpu_ce),
        .cpu_cout   (cpu_cout),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic l, input logic c, input logic [2:0] r,
                                       input logic [3:0] o, input logic [7:0] d);
        return {l, c, r, o, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [16:0] w);
        prog_we    = 1'b1;
        prog_addr  = AW'(a);
        prog_wdata = w;
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic load_basic();
        wr(0, mk(1'b1, 1'b0, SEL_ACCU, ALU_ADD, 8'h01));
        wr(1, mk(1'b1, 1'b0, SEL_REG0, ALU_ADD, 8'h02));
        wr(2, mk(1'b0, 1'b0, SEL_REG0, ALU_ADD, 8'h00));
        wr(3, mk(1'b0, 1'b0, SEL_ACCU, OP_HALT, 8'h00));
    endtask

    // Pulses start, then records cycle-indexed behaviour (cycle 0 = just after the start edge).
    task automatic run_prog(input int max_c, input int ps, input int pl, input int cout_c, input int inj_c);
        ce_n = 0; done_n = 0; done_at = -1; pc_done = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < max_c; c++) begin
            busy_at[c]  = busy;
            carry_at[c] = carry_flag;
            if (cpu_ce === 1'b1) begin
                if (ce_n < 128) begin
                    ce_at[ce_n]  = c;
                    ld_at[ce_n]  = cpu_load;
                    op_at[ce_n]  = cpu_opcode;
                    dat_at[ce_n] = cpu_data;
                end
                ce_n++;
            end
            if (done === 1'b1) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = c;
                    pc_done = int'(pc);
                end
            end
            if (done_at >= 0 && c >= done_at + 3) break;
            pause    = (c >= ps) && (c < ps + pl);
            cpu_cout = (c == cout_c);
            if (c == inj_c) begin
                prog_we    = 1'b1;
                prog_addr  = AW'(3);
                prog_wdata = mk(1'b1, 1'b0, SEL_ACCU, ALU_ADD, 8'h55);
                start      = 1'b1;
            end else begin
                prog_we = 1'b0;
                start   = 1'b0;
            end
            tick();
        end
        pause = 1'b0; cpu_cout = 1'b0; prog_we = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; pause = 1'b0; cpu_cout = 1'b0;
        #12;
        total_n++;
        if ({busy, done, pc, cpu_opcode, cpu_data, cpu_cin, cpu_load, cpu_ce, carry_flag} !== '0)
            $display("FAIL reset_outputs got busy=%b done=%b pc=%0d op=%h d=%h cin=%b ld=%b ce=%b cf=%b want all 0",
                     busy, done, pc, cpu_opcode, cpu_data, cpu_cin, cpu_load, cpu_ce, carry_flag);
        else pass_n++;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        total_n++;
        if (busy !== 1'b0 || cpu_ce !== 1'b0) $display("FAIL idle_after_reset got busy=%b ce=%b want 0 0", busy, cpu_ce);
        else pass_n++;
    endtask

    task automatic test_basic();
        load_basic();
        run_prog(40, -1, 0, -1, -1);
        total_n++;
        if (busy_at[0] !== 1'b1) $display("FAIL basic_busy_start got %b want 1", busy_at[0]); else pass_n++;
        total_n++;
        if (ce_n !== 3) $display("FAIL basic_ce_count got %0d want 3", ce_n); else pass_n++;
        total_n++;
        if (ce_at[0] !== 1 || ce_at[1] !== 3 || ce_at[2] !== 5)
            $display("FAIL basic_ce_timing got %0d,%0d,%0d want 1,3,5", ce_at[0], ce_at[1], ce_at[2]);
        else pass_n++;
        total_n++;
        if ({ld_at[0], ld_at[1], ld_at[2]} !== 3'b110)
            $display("FAIL basic_load got %b%b%b want 110", ld_at[0], ld_at[1], ld_at[2]);
        else pass_n++;
        total_n++;
        if (op_at[0] !== 7'h00 || op_at[1] !== 7'h10 || op_at[2] !== 7'h10)
            $display("FAIL basic_opcode got %h,%h,%h want 00,10,10", op_at[0], op_at[1], op_at[2]);
        else pass_n++;
        total_n++;
        if (dat_at[0] !== 8'h01 || dat_at[1] !== 8'h02 || dat_at[2] !== 8'h00)
            $display("FAIL basic_data got %h,%h,%h want 01,02,00", dat_at[0], dat_at[1], dat_at[2]);
        else pass_n++;
        total_n++;
        if (done_at !== 7 || done_n !== 1 || pc_done !== 3)
            $display("FAIL basic_done got at=%0d n=%0d pc=%0d want 7 1 3", done_at, done_n, pc_done);
        else pass_n++;
        total_n++;
        if (busy_at[7] !== 1'b0 || busy_at[6] !== 1'b1)
            $display("FAIL basic_busy_end got c6=%b c7=%b want 1 0", busy_at[6], busy_at[7]);
        else pass_n++;
    endtask

    task automatic test_pause();
        run_prog(40, 2, 3, -1, -1);
        total_n++;
        if (ce_n !== 3 || ce_at[0] !== 1 || ce_at[1] !== 6 || ce_at[2] !== 8)
            $display("FAIL pause_ce_timing got n=%0d %0d,%0d,%0d want 3 1,6,8", ce_n, ce_at[0], ce_at[1], ce_at[2]);
        else pass_n++;
        total_n++;
        if (op_at[1] !== 7'h10 || dat_at[1] !== 8'h02 || ld_at[1] !== 1'b1)
            $display("FAIL pause_values got op=%h d=%h ld=%b want 10 02 1", op_at[1], dat_at[1], ld_at[1]);
        else pass_n++;
        total_n++;
        if (done_at !== 10 || done_n !== 1) $display("FAIL pause_done got at=%0d n=%0d want 10 1", done_at, done_n);
        else pass_n++;
    endtask

    task automatic test_implicit_halt();
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) wr(i, mk(1'b1, 1'b0, SEL_ACCU, ALU_ADD, 8'(i)));
            else            wr(i, mk(1'b1, 1'b1, SEL_REG6, OP_HALT, 8'(i)));
        end
        run_prog(100, -1, 0, -1, -1);
        total_n++;
        if (ce_n !== 32) $display("FAIL implicit_ce_count got %0d want 32", ce_n); else pass_n++;
        total_n++;
        if (ce_at[0] !== 1 || ce_at[31] !== 63) $display("FAIL implicit_timing got %0d,%0d want 1,63", ce_at[0], ce_at[31]);
        else pass_n++;
        total_n++;
        if (done_at !== 64 || done_n !== 1 || pc_done !== 31)
            $display("FAIL implicit_done got at=%0d n=%0d pc=%0d want 64 1 31", done_at, done_n, pc_done);
        else pass_n++;
        total_n++;
        if (op_at[31] !== 7'h7F || dat_at[31] !== 8'h1F || dat_at[30] !== 8'h1E || op_at[30] !== 7'h00)
            $display("FAIL implicit_values got op31=%h d31=%h op30=%h d30=%h want 7f 1f 00 1e",
                     op_at[31], dat_at[31], op_at[30], dat_at[30]);
        else pass_n++;
        total_n++;
        if (pc !== AW'(31)) $display("FAIL implicit_no_wrap got pc=%0d want 31", pc); else pass_n++;
    endtask

    task automatic test_carry();
        wr(0, mk(1'b1, 1'b0, SEL_ACCU, ALU_ADD, 8'hFF));
        wr(1, mk(1'b0, 1'b0, SEL_ACCU, ALU_ADD, 8'h01));
        wr(2, mk(1'b1, 1'b0, SEL_REG0, ALU_ADD, 8'h05));
        wr(3, mk(1'b0, 1'b0, SEL_ACCU, OP_HALT, 8'h00));
        run_prog(40, -1, 0, 4, -1);
        total_n++;
        if (carry_at[4] !== 1'b0) $display("FAIL carry_before got %b want 0", carry_at[4]); else pass_n++;
        total_n++;
        if (carry_at[5] !== 1'b1) $display("FAIL carry_capture got %b want 1", carry_at[5]); else pass_n++;
        total_n++;
        if (carry_at[7] !== 1'b1 || carry_flag !== 1'b1)
            $display("FAIL carry_after_load got c7=%b now=%b want 1 1", carry_at[7], carry_flag);
        else pass_n++;
    endtask

    task automatic test_ignored_inputs();
        load_basic();
        run_prog(40, -1, 0, -1, 2);
        total_n++;
        if (ce_n !== 3 || done_at !== 7 || done_n !== 1)
            $display("FAIL ignored_during_run got ce=%0d at=%0d n=%0d want 3 7 1", ce_n, done_at, done_n);
        else pass_n++;
        run_prog(40, -1, 0, -1, -1);
        total_n++;
        if (ce_n !== 3 || done_at !== 7 || done_n !== 1)
            $display("FAIL ignored_mem_intact got ce=%0d at=%0d n=%0d want 3 7 1", ce_n, done_at, done_n);
        else pass_n++;
    endtask

    task automatic test_midrun_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total_n++;
        if (cpu_ce !== 1'b1 || busy !== 1'b1) $display("FAIL midrun_pre got ce=%b busy=%b want 1 1", cpu_ce, busy);
        else pass_n++;
        #3;
        rst = 1'b1;
        #1;
        total_n++;
        if ({busy, done, pc, cpu_opcode, cpu_data, cpu_cin, cpu_load, cpu_ce, carry_flag} !== '0)
            $display("FAIL midrun_reset got busy=%b pc=%0d op=%h d=%h ld=%b ce=%b cf=%b want all 0",
                     busy, pc, cpu_opcode, cpu_data, cpu_load, cpu_ce, carry_flag);
        else pass_n++;
        tick();
        rst = 1'b0;
        tick();
        run_prog(40, -1, 0, -1, -1);
        total_n++;
        if (ce_n !== 3 || done_at !== 7) $display("FAIL midrun_rerun got ce=%0d at=%0d want 3 7", ce_n, done_at);
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_implicit_halt();
        test_carry();
        test_ignored_inputs();
        test_midrun_reset();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
